// File: rtl/aer_pkg.sv
// Shared types and constants for the AER output arbiter: handshake FSM states,
// channel-index width helper and drop-counter width.
package aer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } aer_state_e;

    localparam int DROP_CNT_W = 16;

    // Channel index width, never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/aer_fifo.sv
// Per-channel event FIFO. A push while full is dropped even if the same edge pops,
// so the full flag is the single registered decision point for accept/drop.
module aer_fifo #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] wdata_i,
    output logic [ADDR_W-1:0] rdata_o,
    output logic              empty_o,
    output logic              full_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q;
    logic              push_ok, pop_ok;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + PTR_W'(1);
            if (pop_ok)  rptr_q <= rptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    // Storage needs no reset: reads are qualified by the count.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = full_q;

endmodule

// File: rtl/aer_out_arb.sv
// Merges N_CH neuron-core event channels onto one four-phase AER output bus,
// with round-robin channel selection, drop accounting and a synchronised ACK.
module aer_out_arb
    import aer_pkg::*;
#(
    parameter int  N_CH        = 4,
    parameter int  ADDR_W      = 8,
    parameter int  DEPTH       = 8,
    parameter int  SYNC_STAGES = 2,
    localparam int CH_W        = ch_w(N_CH)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_CH-1:0]        ch_evt_valid_i,
    input  logic [N_CH*ADDR_W-1:0] ch_evt_addr_i,
    output logic [N_CH-1:0]        ch_full_o,
    output logic [N_CH-1:0]        ch_ovf_o,
    output logic [DROP_CNT_W-1:0]  drop_cnt_o,
    output logic [CH_W+ADDR_W-1:0] aerout_addr_o,
    output logic                   aerout_req_o,
    input  logic                   aerout_ack_i,
    output logic                   aerout_ctrl_busy_o,
    output aer_state_e             state_o
);
    logic [N_CH-1:0]        fifo_empty, fifo_full, pop_vec, drop_vec;
    logic [ADDR_W-1:0]      fifo_rdata [N_CH];

    aer_state_e             state_q;
    logic                   req_q;
    logic [CH_W+ADDR_W-1:0] addr_q;
    logic [CH_W-1:0]        rr_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [N_CH-1:0]        ovf_q;
    logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic                   ack_s;
    logic                   grant_vld;
    logic [CH_W-1:0]        grant_idx, cand;
    logic [4:0]             drop_k;
    logic [DROP_CNT_W:0]    cnt_sum;

    for (genvar c = 0; c < N_CH; c++) begin : g_fifo
        aer_fifo #(
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (ch_evt_valid_i[c]),
            .pop_i   (pop_vec[c]),
            .wdata_i (ch_evt_addr_i[c*ADDR_W +: ADDR_W]),
            .rdata_o (fifo_rdata[c]),
            .empty_o (fifo_empty[c]),
            .full_o  (fifo_full[c])
        );
    end

    assign ack_s    = sync_q[SYNC_STAGES-1];
    assign drop_vec = ch_evt_valid_i & fifo_full;

    // Search starts one past the last granted channel and wraps around.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = CH_W'((int'(rr_q) + i) % N_CH);
            if (!grant_vld && !fifo_empty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        pop_vec = '0;
        if (state_q == ST_IDLE && grant_vld) pop_vec[grant_idx] = 1'b1;
    end

    always_comb begin
        drop_k = '0;
        for (int c = 0; c < N_CH; c++) begin
            drop_k = drop_k + 5'(drop_vec[c]);
        end
        cnt_sum    = {1'b0, drop_cnt_q} + (DROP_CNT_W+1)'(drop_k);
        drop_cnt_d = cnt_sum[DROP_CNT_W] ? '1 : cnt_sum[DROP_CNT_W-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            addr_q     <= '0;
            rr_q       <= CH_W'(N_CH - 1);
            sync_q     <= '0;
            ovf_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], aerout_ack_i};
            ovf_q      <= ovf_q | drop_vec;
            drop_cnt_q <= drop_cnt_d;
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld) begin
                        addr_q  <= {grant_idx, fifo_rdata[grant_idx]};
                        rr_q    <= grant_idx;
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack_s) begin
                        req_q   <= 1'b0;
                        state_q <= ST_WAIT_LOW;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!ack_s) state_q <= ST_IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ch_full_o          = fifo_full;
    assign ch_ovf_o           = ovf_q;
    assign drop_cnt_o         = drop_cnt_q;
    assign aerout_addr_o      = addr_q;
    assign aerout_req_o       = req_q;
    assign aerout_ctrl_busy_o = (|(~fifo_empty)) || (state_q != ST_IDLE);
    assign state_o            = state_q;

endmodule

// File: tb/tb_aer_out_arb.sv
// Directed bench for aer_out_arb: expected grants are queued as stimulus is
// issued and a monitor pops one per rising REQ.
module tb_aer_out_arb;
    import aer_pkg::*;

    localparam int N_CH = 4;
    localparam int AW   = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] valid = '0;
    logic [31:0]     addr_bus = '0;
    logic [N_CH-1:0] full, ovf;
    logic [15:0]     drop_cnt;
    logic [9:0]      addr;
    logic            req, busy, ack;
    aer_state_e      state;

    bit   ack_auto = 1'b0;
    logic ack_resp = 1'b0;
    logic ack_man  = 1'b0;
    assign ack = ack_auto ? ack_resp : ack_man;

    int n_checks = 0;
    int n_pass   = 0;
    logic [9:0] exp_q[$];

    aer_out_arb dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .ch_evt_valid_i     (valid),
        .ch_evt_addr_i      (addr_bus),
        .ch_full_o          (full),
        .ch_ovf_o           (ovf),
        .drop_cnt_o         (drop_cnt),
        .aerout_addr_o      (addr),
        .aerout_req_o       (req),
        .aerout_ack_i       (ack),
        .aerout_ctrl_busy_o (busy),
        .state_o            (state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [9:0] ent(input int ch, input logic [7:0] a);
        return {ch[1:0], a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    // Driver tasks
    task automatic drive(input logic [N_CH-1:0] mask, input logic [31:0] addrs);
        @(negedge clk);
        valid    = mask;
        addr_bus = addrs;
        @(posedge clk);
        #1;
        valid = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        valid = '0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check({name, "_busy_low"}, 32'(busy), 32'd0);
        check({name, "_drained"}, exp_q.size(), 32'd0);
    endtask

    // ACK responder: ACK follows REQ one clock later
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ack_resp = prev;
            prev     = req;
        end
    end

    // Scoreboard monitor
    initial begin
        logic [9:0] cur;
        bit seen;
        seen = 1'b0;
        cur  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else if (req && !seen) begin
                seen = 1'b1;
                cur  = addr;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_req: got addr %0h with no event expected", addr);
                end else begin
                    check("grant_addr", 32'(addr), 32'(exp_q.pop_front()));
                end
            end else if (!req && seen) begin
                seen = 1'b0;
                check("addr_hold", 32'(addr), 32'(cur));
            end
        end
    end

    initial begin
        bit hit;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req", 32'(req), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state), 32'(ST_IDLE));
        rst = 1'b0;

        // Single event with latency check
        ack_auto = 1'b1;
        exp_q.push_back(ent(2, 8'h05));
        drive(4'b0100, 32'h0005_0000);
        check("lat_capture_edge", 32'(req), 32'd0);
        @(posedge clk);
        #1;
        check("lat_next_edge", 32'(req), 32'd1);
        check("single_addr", 32'(addr), 32'h205);
        wait_idle("single");

        // Round robin from reset
        do_reset();
        exp_q.push_back(ent(0, 8'hA1));
        exp_q.push_back(ent(1, 8'hB1));
        exp_q.push_back(ent(3, 8'hD1));
        exp_q.push_back(ent(0, 8'hA2));
        drive(4'b1011, 32'hD1_00_B1_A1);
        drive(4'b0001, 32'h0000_00A2);
        wait_idle("rr");

        // Overflow with ACK held low
        do_reset();
        ack_auto = 1'b0;
        for (int i = 0; i < 9; i++) exp_q.push_back(ent(1, 8'(8'h10 + i)));
        for (int i = 0; i < 10; i++) begin
            drive(4'b0010, 32'(8'(8'h10 + i)) << 8);
            if (i == 7) check("ovf_not_full_8", 32'(full), 32'd0);
            if (i == 8) check("ovf_full_9", 32'(full), 32'b0010);
        end
        check("ovf_flag", 32'(ovf), 32'b0010);
        check("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
        check("ovf_req_held", 32'(req), 32'd1);
        ack_auto = 1'b1;
        wait_idle("ovf");
        check("ovf_full_clear", 32'(full), 32'd0);
        check("ovf_sticky", 32'(ovf), 32'b0010);

        // Full FIFO with a push on its pop edge
        do_reset();
        ack_auto = 1'b0;
        exp_q.push_back(ent(3, 8'h33));
        drive(4'b1000, 32'h3300_0000);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(ent(0, 8'(8'h40 + i)));
            drive(4'b0001, 32'(8'(8'h40 + i)));
        end
        check("race_full", 32'(full), 32'b0001);
        check("race_drop_before", 32'(drop_cnt), 32'd0);
        ack_auto = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (state == ST_IDLE) begin
                hit = 1'b1;
                break;
            end
        end
        check("race_reach_idle", 32'(hit), 32'd1);
        valid    = 4'b0001;
        addr_bus = 32'h0000_0048;
        @(posedge clk);
        #1;
        valid = '0;
        check("race_drop_cnt", 32'(drop_cnt), 32'd1);
        check("race_ovf", 32'(ovf), 32'b0001);
        check("race_not_full", 32'(full), 32'd0);
        wait_idle("race");

        // Reset during WAIT_LOW with events queued
        do_reset();
        exp_q.push_back(ent(0, 8'h50));
        drive(4'b1111, 32'h53_52_51_50);
        hit = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (state == ST_WAIT_LOW) begin
                hit = 1'b1;
                break;
            end
        end
        check("midrst_reach_wait_low", 32'(hit), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_req", 32'(req), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_state", 32'(state), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_quiet_req", 32'(req), 32'd0);
        check("midrst_quiet_busy", 32'(busy), 32'd0);
        exp_q.push_back(ent(1, 8'h77));
        drive(4'b0010, 32'h0000_7700);
        wait_idle("midrst_new");

        // Sub-cycle ACK glitch during REQ
        do_reset();
        ack_auto = 1'b0;
        exp_q.push_back(ent(2, 8'h99));
        drive(4'b0100, 32'h0099_0000);
        @(posedge clk);
        #1;
        check("glitch_req_up", 32'(req), 32'd1);
        @(negedge clk);
        ack_man = 1'b1;
        #4;
        ack_man = 1'b0;
        repeat (6) @(negedge clk);
        check("glitch_state", 32'(state), 32'(ST_REQ));
        check("glitch_req_held", 32'(req), 32'd1);
        ack_auto = 1'b1;
        wait_idle("glitch");

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
